// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage vs. buffered long-latency unit results; optional same-cycle LU bypass via RFARB_BYPASS_EN.
// Latency: WB path is combinational (0 cycles); LU path >= 1 cycle through the FIFO (0 cycles when bypassed into an empty, idle port).
// Backpressure: lu_ready = !full (registered count only); stall_WB freezes WB for one cycle when the FIFO head has waited MAX_WAIT cycles.
module rf_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_regWrite,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic                     lu_valid,
    input  logic [4:0]               lu_rd,
    input  logic [31:0]              lu_data,
    output logic                     lu_ready,
    output logic                     stall_WB,
    output logic                     regWrite,
    output logic [4:0]               rd_WB,
    output logic [31:0]              writeData,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LP_DEPTH    = CW'(DEPTH);
    localparam logic [3:0]    LP_MAX_WAIT = 4'(MAX_WAIT);

    // LU result buffer; a cleared valid bit marks an entry superseded by a WB write
    logic          r_vld  [DEPTH];
    logic [4:0]    r_rd   [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_wait;
    logic          r_stall;

    logic          w_empty;
    logic          w_full;
    logic          w_head_vld;
    logic          w_pop;
    logic          w_push;
    logic          w_wb_grant;
    logic          w_kill_head;
    logic          w_bypass;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == LP_DEPTH);
    assign w_head_vld  = !w_empty && r_vld[r_rptr];
    assign w_kill_head = w_wb_grant && w_head_vld && (r_rd[r_rptr] == wb_rd);
    assign w_push      = reset && lu_valid && !w_full && !w_bypass;

    assign lu_ready    = !w_full;
    assign stall_WB    = r_stall;
    assign fifo_count  = r_count;

    // Port grant in priority order: forced drain, WB, valid head, (bypass); also decides the pop
    always_comb begin
        regWrite   = 1'b0;
        rd_WB      = 5'd0;
        writeData  = 32'd0;
        w_pop      = 1'b0;
        w_wb_grant = 1'b0;
        w_bypass   = 1'b0;
        if (reset) begin
            if (r_stall) begin
                // WB request is ignored; the pipeline holds and re-presents it
                if (w_head_vld) begin
                    regWrite  = 1'b1;
                    rd_WB     = r_rd[r_rptr];
                    writeData = r_data[r_rptr];
                end
                w_pop = !w_empty;
            end else if (wb_regWrite) begin
                regWrite   = 1'b1;
                rd_WB      = wb_rd;
                writeData  = wb_data;
                w_wb_grant = 1'b1;
                // a killed head leaves without needing the port
                w_pop      = !w_empty && !r_vld[r_rptr];
            end else if (w_head_vld) begin
                regWrite  = 1'b1;
                rd_WB     = r_rd[r_rptr];
                writeData = r_data[r_rptr];
                w_pop     = 1'b1;
            end else begin
                w_pop = !w_empty;
`ifdef RFARB_BYPASS_EN
                if (w_empty && lu_valid) begin
                    regWrite  = 1'b1;
                    rd_WB     = lu_rd;
                    writeData = lu_data;
                    w_bypass  = 1'b1;
                end
`endif
            end
        end
    end

    // Pending-write mask: one-hot OR of every still-valid buffered destination
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                pending_mask[r_rd[i]] = 1'b1;
            end
        end
    end

    // FIFO state: kill on WB grant, then pop, then push (a same-cycle push survives the kill)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]  <= 1'b0;
                r_rd[i]   <= 5'd0;
                r_data[i] <= 32'd0;
            end
        end else begin
            if (w_wb_grant) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_vld[i] && (r_rd[i] == wb_rd)) begin
                        r_vld[i] <= 1'b0;
                    end
                end
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + PW'(1);
            end
            if (w_push) begin
                r_vld[r_wptr]  <= 1'b1;
                r_rd[r_wptr]   <= lu_rd;
                r_data[r_wptr] <= lu_data;
                r_wptr         <= r_wptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Starvation tracking: count denied cycles of a valid head, force one WB freeze at MAX_WAIT
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait  <= 4'd0;
            r_stall <= 1'b0;
        end else begin
            if (w_pop || w_empty) begin
                r_wait <= 4'd0;
            end else if (w_head_vld && (r_wait != LP_MAX_WAIT)) begin
                r_wait <= r_wait + 4'd1;
            end
            r_stall <= (r_wait == LP_MAX_WAIT) && w_head_vld && !w_pop && !w_kill_head;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_regWrite = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_data = 32'd0;
    logic        lu_ready;
    logic        stall_WB;
    logic        regWrite;
    logic [4:0]  rd_WB;
    logic [31:0] writeData;
    logic [31:0] pending_mask;
    logic [1:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    rf_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .stall_WB     (stall_WB),
        .regWrite     (regWrite),
        .rd_WB        (rd_WB),
        .writeData    (writeData),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic wr_t mk(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        return w;
    endfunction

    // Scoreboard: every port write must match the oldest expected write
    always @(negedge clk) begin
        if (regWrite === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL port_write: got unexpected rd=%0d data=%h, none expected", rd_WB, writeData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({rd_WB, writeData} !== {e.rd, e.data}) begin
                    n_err++;
                    $display("FAIL port_write: got rd=%0d data=%h, want rd=%0d data=%h", rd_WB, writeData, e.rd, e.data);
                end
            end
        end else if (regWrite !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL port_write: regWrite=%b, want 0/1", regWrite);
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_regWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if ({stall_WB, lu_ready, regWrite, rd_WB, writeData, pending_mask, fifo_count} !==
                {1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0}) begin
                n_err++;
                $display("FAIL reset_idle c%0d: got stall=%b rdy=%b we=%b rd=%0d data=%h mask=%h cnt=%0d, want 0 1 0 0 0 0 0",
                         c, stall_WB, lu_ready, regWrite, rd_WB, writeData, pending_mask, fifo_count);
            end
            next_cyc();
        end
    endtask

    task automatic test_lu_alone();
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hCAFE0001;
        exp_q.push_back(mk(5'd5, 32'hCAFE0001));
        #1;
        n_vec++;
        if (regWrite !== 1'b0) begin n_err++; $display("FAIL lu_latency: regWrite=%b in push cycle, want 0", regWrite); end
        next_cyc();
        idle_inputs();
        #1;
        n_vec++;
        if (pending_mask !== 32'h20) begin n_err++; $display("FAIL lu_mask: got %h want 00000020", pending_mask); end
        n_vec++;
        if (regWrite !== 1'b1 || fifo_count !== 2'd1) begin
            n_err++; $display("FAIL lu_drain: got we=%b cnt=%0d want we=1 cnt=1", regWrite, fifo_count);
        end
        next_cyc();
        n_vec++;
        if (pending_mask !== 32'h0 || fifo_count !== 2'd0) begin
            n_err++; $display("FAIL lu_after: got mask=%h cnt=%0d want 0 0", pending_mask, fifo_count);
        end
    endtask

    task automatic test_bypass();
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h42;
        exp_q.push_back(mk(5'd9, 32'h42));
        #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd_WB !== 5'd9 || writeData !== 32'h42) begin
            n_err++; $display("FAIL bypass_write: got we=%b rd=%0d data=%h want 1 9 42", regWrite, rd_WB, writeData);
        end
        next_cyc();
        idle_inputs();
        #1;
        n_vec++;
        if (fifo_count !== 2'd0 || pending_mask !== 32'h0) begin
            n_err++; $display("FAIL bypass_nopush: got cnt=%0d mask=%h want 0 0", fifo_count, pending_mask);
        end
        next_cyc();
    endtask

    task automatic test_fill();
        // A: WB writes r0 (passed through), LU pushes rd3
        wb_regWrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hA0;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h300;
        exp_q.push_back(mk(5'd0, 32'hA0));
        #1;
        n_vec++;
        if (lu_ready !== 1'b1) begin n_err++; $display("FAIL fill_rdyA: got %b want 1", lu_ready); end
        next_cyc();
        // B
        wb_rd = 5'd11; wb_data = 32'hB0; lu_rd = 5'd4; lu_data = 32'h400;
        exp_q.push_back(mk(5'd11, 32'hB0));
        #1;
        n_vec++;
        if (fifo_count !== 2'd1 || pending_mask !== 32'h8) begin
            n_err++; $display("FAIL fill_B: got cnt=%0d mask=%h want 1 00000008", fifo_count, pending_mask);
        end
        next_cyc();
        // C: full, third offer must be held
        wb_rd = 5'd12; wb_data = 32'hC0; lu_rd = 5'd6; lu_data = 32'h600;
        exp_q.push_back(mk(5'd12, 32'hC0));
        #1;
        n_vec++;
        if (lu_ready !== 1'b0 || fifo_count !== 2'd2 || pending_mask !== 32'h18) begin
            n_err++; $display("FAIL fill_full: got rdy=%b cnt=%0d mask=%h want 0 2 00000018", lu_ready, fifo_count, pending_mask);
        end
        next_cyc();
        // D: head drains; still full so no push despite the pop
        wb_regWrite = 1'b0;
        exp_q.push_back(mk(5'd3, 32'h300));
        #1;
        n_vec++;
        if (lu_ready !== 1'b0 || fifo_count !== 2'd2 || stall_WB !== 1'b0) begin
            n_err++; $display("FAIL fill_D: got rdy=%b cnt=%0d stall=%b want 0 2 0", lu_ready, fifo_count, stall_WB);
        end
        next_cyc();
        // E: held offer accepted now
        exp_q.push_back(mk(5'd4, 32'h400));
        #1;
        n_vec++;
        if (lu_ready !== 1'b1 || fifo_count !== 2'd1) begin
            n_err++; $display("FAIL fill_E: got rdy=%b cnt=%0d want 1 1", lu_ready, fifo_count);
        end
        next_cyc();
        idle_inputs();
        exp_q.push_back(mk(5'd6, 32'h600));
        #1;
        n_vec++;
        if (fifo_count !== 2'd1 || pending_mask !== 32'h40) begin
            n_err++; $display("FAIL fill_F: got cnt=%0d mask=%h want 1 00000040", fifo_count, pending_mask);
        end
        next_cyc();
        n_vec++;
        if (fifo_count !== 2'd0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL fill_end: got cnt=%0d pending=%0d want 0 0", fifo_count, exp_q.size());
        end
    endtask

    task automatic test_starvation();
        int k;
        for (int c = 0; c < 8; c++) begin
            k = (c == 7) ? 6 : c;
            wb_regWrite = 1'b1; wb_rd = 5'(1 + k); wb_data = 32'h100 + 32'(k);
            lu_valid = (c == 0); lu_rd = 5'd20; lu_data = 32'h5000;
            if (c == 6) exp_q.push_back(mk(5'd20, 32'h5000));
            else        exp_q.push_back(mk(wb_rd, wb_data));
            #1;
            n_vec++;
            if (stall_WB !== (c == 6)) begin
                n_err++; $display("FAIL starve_stall c%0d: got %b want %b", c, stall_WB, (c == 6));
            end
            next_cyc();
        end
        idle_inputs();
        #1;
        n_vec++;
        if (fifo_count !== 2'd0 || stall_WB !== 1'b0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL starve_end: got cnt=%0d stall=%b pending=%0d want 0 0 0", fifo_count, stall_WB, exp_q.size());
        end
        next_cyc();
    endtask

    task automatic test_kill();
        wb_regWrite = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h777;
        exp_q.push_back(mk(5'd2, 32'h22));
        next_cyc();
        lu_valid = 1'b0; wb_rd = 5'd7; wb_data = 32'h11;
        exp_q.push_back(mk(5'd7, 32'h11));
        #1;
        n_vec++;
        if (pending_mask !== 32'h80 || fifo_count !== 2'd1) begin
            n_err++; $display("FAIL kill_pre: got mask=%h cnt=%0d want 00000080 1", pending_mask, fifo_count);
        end
        next_cyc();
        idle_inputs();
        #1;
        n_vec++;
        if (pending_mask !== 32'h0 || fifo_count !== 2'd1 || regWrite !== 1'b0) begin
            n_err++; $display("FAIL kill_pop: got mask=%h cnt=%0d we=%b want 0 1 0", pending_mask, fifo_count, regWrite);
        end
        next_cyc();
        n_vec++;
        if (fifo_count !== 2'd0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL kill_end: got cnt=%0d pending=%0d want 0 0", fifo_count, exp_q.size());
        end
    endtask

    task automatic test_push_vs_wb();
        wb_regWrite = 1'b1; wb_rd = 5'd8; wb_data = 32'h88;
        lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h99;
        exp_q.push_back(mk(5'd8, 32'h88));
        next_cyc();
        idle_inputs();
        exp_q.push_back(mk(5'd8, 32'h99));
        #1;
        n_vec++;
        if (pending_mask !== 32'h100 || fifo_count !== 2'd1) begin
            n_err++; $display("FAIL same_cycle_push: got mask=%h cnt=%0d want 00000100 1", pending_mask, fifo_count);
        end
        next_cyc();
        n_vec++;
        if (fifo_count !== 2'd0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL same_cycle_end: got cnt=%0d pending=%0d want 0 0", fifo_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        wb_regWrite = 1'b1; wb_rd = 5'd13; wb_data = 32'hD0;
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC0;
        exp_q.push_back(mk(5'd13, 32'hD0));
        next_cyc();
        idle_inputs();
        reset = 1'b0;
        #1;
        n_vec++;
        if (regWrite !== 1'b0 || pending_mask !== 32'h1000 || fifo_count !== 2'd1) begin
            n_err++; $display("FAIL rstmid_hold: got we=%b mask=%h cnt=%0d want 0 00001000 1", regWrite, pending_mask, fifo_count);
        end
        next_cyc();
        reset = 1'b1;
        #1;
        n_vec++;
        if (fifo_count !== 2'd0 || pending_mask !== 32'h0 || lu_ready !== 1'b1 || regWrite !== 1'b0) begin
            n_err++; $display("FAIL rstmid_clear: got cnt=%0d mask=%h rdy=%b we=%b want 0 0 1 0", fifo_count, pending_mask, lu_ready, regWrite);
        end
        next_cyc();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rstmid_end: got %0d writes outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
`ifdef RFARB_BYPASS_EN
        test_bypass();
`else
        test_lu_alone();
`endif
        test_fill();
        test_starvation();
        test_kill();
        test_push_vs_wb();
        test_reset_mid();
        next_cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates the register file's single write port between the pipeline write-back stage (WB) and a long-latency unit (LU), such as a multi-cycle multiply/divide or a memory refill return. LU results are held in a small FIFO and drained into idle write-port cycles. If an LU result has waited too long, the block freezes WB for one cycle so the result can drain. It also publishes a pending-write mask so the decode-stage hazard logic can stall readers of registers that have not yet been written.

## Interface
- DEPTH, 2: LU buffer entries; power of two, 2..8.
- MAX_WAIT, 4: cycles a valid FIFO head may be denied before WB is stalled; 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- wb_regWrite  in  1  WB requests a register write this cycle.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- lu_valid  in  1  LU offers a result.
- lu_rd  in  5  LU destination register.
- lu_data  in  32  LU result.
- lu_ready  out  1  FIFO can accept an entry; equals !full.
- stall_WB  out  1  registered; WB must freeze and hold its request this cycle.
- regWrite  out  1  write enable to the register file.
- rd_WB  out  5  write address to the register file.
- writeData  out  32  write data to the register file.
- pending_mask  out  32  bit r is set iff a valid FIFO entry targets r.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries, valid or killed.

## Operation
- Push: lu_valid && lu_ready writes {valid=1, rd, data} at the tail. lu_ready depends only on registered count. When full, no push is accepted even if a pop occurs in the same cycle.
- Port grant, evaluated each cycle in priority order:
  1. stall_WB=1 → FIFO head is written. wb_regWrite is ignored; the pipeline re-presents it next cycle.
  2. wb_regWrite=1 → WB is written.
  3. FIFO head valid → head is written and popped.
  4. Otherwise regWrite=0, and rd_WB and writeData are driven 0.
- Kill: when WB is granted, every valid entry with rd==wb_rd gets its valid bit cleared. The LU result is older, so the WB result wins.
- A killed (invalid) head is popped without using the port, in the same cycle as any port grant. At most one pop occurs per cycle.
- Wait counter:
  - Increments each cycle the head is valid and not popped.
  - Clears on pop or when the FIFO is empty.
  - When it equals MAX_WAIT, stall_WB is asserted for the next cycle only. The forced pop in that cycle clears the counter.
- pending_mask is the OR of the one-hot decoded rd of all valid entries. It is recomputed from state, so it is effectively registered.
- Writes to r0 are passed through unchanged; the register file discards them.

## Timing
- Reset (reset=0 at an edge):
  - FIFO empty, all valid bits 0, wait counter 0.
  - stall_WB=0, lu_ready=1, pending_mask=0, fifo_count=0.
  - regWrite=0, rd_WB=0, writeData=0.
  - Reset mid-operation discards buffered LU results.
- WB path: combinational, zero latency from wb_* to the write-port outputs.
- LU path: a result accepted in cycle N is written no earlier than cycle N+1, unless the bypass feature is compiled in.
- Worst case: a valid head reaches the port within MAX_WAIT+1 cycles of becoming head.
- Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- Simultaneous push and pop when not full: count is unchanged.
- A push whose rd matches a WB write in the same cycle is not killed. The LU result is then treated as younger.

## Configuration
- RFARB_BYPASS_EN defined:
  - If the FIFO is empty, wb_regWrite=0, stall_WB=0 and lu_valid=1, the LU result is written to the port in the same cycle.
  - It is not pushed, and pending_mask is unaffected.
- RFARB_BYPASS_EN undefined: every LU result passes through the FIFO, with a minimum latency of 1 cycle.

## Test plan
- Reset, then idle: with reset=0 held for 2 cycles then released, all outputs are 0 except lu_ready=1, and they stay so with no inputs.
- LU alone (bypass off):
  - Stimulus: lu_valid with rd=5, data=0xCAFE0001 in cycle 1.
  - Required: pending_mask=0x20 in cycle 2; regWrite=1, rd_WB=5, writeData=0xCAFE0001 in cycle 2; mask 0 in cycle 3.
- Fill and backpressure (DEPTH=2):
  - Stimulus: LU pushes to rd 3 and 4 while WB writes every cycle.
  - Required: lu_ready=0 and fifo_count=2; a third LU offer is held and not accepted.
- Starvation (MAX_WAIT=4):
  - Stimulus: FIFO head is valid and WB writes every cycle.
  - Required: stall_WB=1 exactly in the 5th cycle after the head appears; the head is written that cycle; WB is written the next cycle with its held values.
- Kill:
  - Stimulus: buffered LU entry rd=7; WB writes rd=7, data=0x11.
  - Required: port writes 0x11; pending_mask bit 7 clears; the entry is popped without a port write.
- Bypass (RFARB_BYPASS_EN defined):
  - Stimulus: FIFO empty, no WB request, LU offers rd=9, data=0x42.
  - Required: same-cycle regWrite=1, rd_WB=9, writeData=0x42; fifo_count stays 0.
